// File: rtl/probe_scanner.sv
// Debug probe access: GET/PUT/SCAN/RELEASE over valid/ready command and response ports.
// Optional force registers are built only when PROBE_SCANNER_FORCE_EN is defined.
module probe_scanner #(
    parameter int NUM_CH = 8,
    parameter int WIDTH  = 32,
    parameter int IDX_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*WIDTH-1:0] probe_in,
    output logic [NUM_CH-1:0]       force_en,
    output logic [NUM_CH*WIDTH-1:0] force_val,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [IDX_W-1:0]        cmd_idx,
    input  logic [WIDTH-1:0]        cmd_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDX_W-1:0]        rsp_idx,
    output logic [WIDTH-1:0]        rsp_data,
    output logic                    rsp_err,
    output logic                    rsp_last
);

    localparam logic [1:0] OP_GET  = 2'b00;
    localparam logic [1:0] OP_PUT  = 2'b01;
    localparam logic [1:0] OP_SCAN = 2'b10;
    localparam logic [1:0] OP_REL  = 2'b11;

    localparam logic [IDX_W:0]   CH_LIMIT = (IDX_W+1)'(NUM_CH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

`ifdef PROBE_SCANNER_FORCE_EN
    localparam logic FORCE_OK = 1'b1;
`else
    localparam logic FORCE_OK = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RESP, SCAN} state_t;
    state_t state;

    logic             accept;
    logic             rsp_hs;
    logic             in_range;
    logic             op_ok;
    logic [IDX_W-1:0] next_beat;
    logic [IDX_W-1:0] sel_idx;
    logic [WIDTH-1:0] sel_data;

    assign accept    = cmd_valid && cmd_ready;
    assign rsp_hs    = rsp_valid && rsp_ready;
    assign in_range  = ({1'b0, cmd_idx} < CH_LIMIT);
    assign op_ok     = (cmd_op == OP_GET) || FORCE_OK;
    assign next_beat = rsp_idx + IDX_W'(1);

    // One shared channel mux: command target while idle, next beat while scanning.
    always_comb begin
        sel_data = '0;
        if (state == IDLE)
            sel_idx = (cmd_op == OP_SCAN) ? '0 : cmd_idx;
        else
            sel_idx = next_beat;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_idx == IDX_W'(i))
                sel_data = probe_in[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_idx   <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            rsp_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        rsp_valid <= 1'b1;
                        if (cmd_op == OP_SCAN) begin
                            state    <= SCAN;
                            rsp_idx  <= '0;
                            rsp_data <= sel_data;
                            rsp_err  <= 1'b0;
                            rsp_last <= (NUM_CH == 1);
                        end else begin
                            state    <= RESP;
                            rsp_idx  <= cmd_idx;
                            rsp_last <= 1'b1;
                            if (!in_range || !op_ok) begin
                                rsp_err  <= 1'b1;
                                rsp_data <= '0;
                            end else begin
                                rsp_err  <= 1'b0;
                                rsp_data <= (cmd_op == OP_GET) ? sel_data :
                                            (cmd_op == OP_PUT) ? cmd_data : '0;
                            end
                        end
                    end
                end
                RESP: begin
                    if (rsp_hs) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                SCAN: begin
                    if (rsp_hs) begin
                        if (rsp_last) begin
                            state     <= IDLE;
                            rsp_valid <= 1'b0;
                            cmd_ready <= 1'b1;
                        end else begin
                            rsp_idx  <= next_beat;
                            rsp_data <= sel_data;
                            rsp_last <= (next_beat == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PROBE_SCANNER_FORCE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            force_en  <= '0;
            force_val <= '0;
        end else if (accept && in_range) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cmd_idx == IDX_W'(i)) begin
                    if (cmd_op == OP_PUT) begin
                        force_en[i]                  <= 1'b1;
                        force_val[i*WIDTH +: WIDTH]  <= cmd_data;
                    end else if (cmd_op == OP_REL) begin
                        force_en[i] <= 1'b0;
                    end
                end
            end
        end
    end
`else
    logic unused_cmd_data;
    assign unused_cmd_data = ^cmd_data;
    assign force_en  = '0;
    assign force_val = '0;
`endif

endmodule

// File: tb/tb_probe_scanner.sv
// Directed bench for probe_scanner (NUM_CH=8, WIDTH=32, IDX_W=8); expectations follow
// whether PROBE_SCANNER_FORCE_EN is defined for the build.
module tb_probe_scanner;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] probe_in;
    logic [7:0]   force_en;
    logic [255:0] force_val;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [7:0]   cmd_idx;
    logic [31:0]  cmd_data;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [7:0]   rsp_idx;
    logic [31:0]  rsp_data;
    logic         rsp_err;
    logic         rsp_last;

    int errs   = 0;
    int checks = 0;

    logic [7:0]  r_idx;
    logic [31:0] r_data;
    logic        r_err;
    logic        r_last;

    probe_scanner #(.NUM_CH(8), .WIDTH(32), .IDX_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .probe_in(probe_in),
        .force_en(force_en), .force_val(force_val),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_idx(cmd_idx), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_idx(rsp_idx),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_last(rsp_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_ch(input int i, input logic [31:0] v);
        probe_in[i*32 +: 32] = v;
    endtask

    task automatic wait_ready(input string t);
        int n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({t, " accept"}, 64'(cmd_ready), 64'd1);
    endtask

    // Single command with one-cycle response check, then a clean handshake.
    task automatic do_cmd(input logic [1:0] op, input logic [7:0] idx,
                          input logic [31:0] data, input string t);
        @(negedge clk);
        cmd_op = op; cmd_idx = idx; cmd_data = data; cmd_valid = 1'b1; rsp_ready = 1'b0;
        wait_ready(t);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk({t, " rsp_valid"}, 64'(rsp_valid), 64'd1);
        chk({t, " busy"}, 64'(cmd_ready), 64'd0);
        r_idx = rsp_idx; r_data = rsp_data; r_err = rsp_err; r_last = rsp_last;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({t, " done"}, 64'({rsp_valid, cmd_ready}), 64'b01);
    endtask

    task automatic scan_start(input string t);
        @(negedge clk);
        cmd_op = 2'b10; cmd_idx = 8'hFF; cmd_valid = 1'b1; rsp_ready = 1'b1;
        wait_ready(t);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_idx = '0; cmd_data = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) set_ch(i, 32'(i * 'h11));
        set_ch(3, 32'hDEADBEEF);

        repeat (3) @(negedge clk);
        chk("reset cmd_ready", 64'(cmd_ready), 64'd0);
        chk("reset rsp", 64'({rsp_valid, rsp_err, rsp_last, rsp_idx}), 64'd0);
        chk("reset rsp_data", 64'(rsp_data), 64'd0);
        chk("reset force_en", 64'(force_en), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset cmd_ready", 64'(cmd_ready), 64'd1);

        do_cmd(2'b00, 8'd3, 32'd0, "get3");
        chk("get3 fields", 64'({r_idx, r_err, r_last}), 64'({8'd3, 1'b0, 1'b1}));
        chk("get3 data", 64'(r_data), 64'hDEADBEEF);
        set_ch(3, 32'h33);

        do_cmd(2'b01, 8'd5, 32'h1234, "put5");
`ifdef PROBE_SCANNER_FORCE_EN
        chk("put5 rsp", 64'({r_err, r_data}), 64'({1'b0, 32'h1234}));
        chk("put5 force_en", 64'(force_en), 64'h20);
        chk("put5 force_val", 64'(force_val[5*32 +: 32]), 64'h1234);
`else
        chk("put5 rsp", 64'({r_err, r_data}), 64'({1'b1, 32'h0}));
        chk("put5 force_en", 64'(force_en), 64'h00);
`endif

        do_cmd(2'b11, 8'd5, 32'h0, "rel5");
`ifdef PROBE_SCANNER_FORCE_EN
        chk("rel5 rsp", 64'({r_err, r_data}), 64'({1'b0, 32'h0}));
        chk("rel5 force_en", 64'(force_en), 64'h00);
        chk("rel5 force_val", 64'(force_val[5*32 +: 32]), 64'h1234);
`else
        chk("rel5 rsp", 64'({r_err, r_data}), 64'({1'b1, 32'h0}));
        chk("rel5 force_en", 64'(force_en), 64'h00);
`endif

        do_cmd(2'b00, 8'd8, 32'h0, "get8");
        chk("get8 rsp", 64'({r_idx, r_err, r_last, r_data}), 64'({8'd8, 1'b1, 1'b1, 32'h0}));
        do_cmd(2'b01, 8'd200, 32'hFF, "put200");
        chk("put200 rsp", 64'({r_idx, r_err, r_data}), 64'({8'd200, 1'b1, 32'h0}));
        chk("put200 force_en", 64'(force_en), 64'h00);

        // Full scan with a three-cycle stall on beat 2; ch2 changes during the stall.
        scan_start("scan");
        for (int b = 0; b < 8; b++) begin
            chk($sformatf("scan beat%0d", b), 64'({rsp_valid, rsp_idx, rsp_last}),
                64'({1'b1, 8'(b), (b == 7)}));
            chk($sformatf("scan data%0d", b), 64'(rsp_data), 64'(b * 'h11));
            if (b == 2) begin
                rsp_ready = 1'b0;
                set_ch(2, 32'hAAAA);
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    chk($sformatf("stall%0d", s), 64'({rsp_valid, rsp_idx, rsp_last, rsp_data}),
                        64'({1'b1, 8'd2, 1'b0, 32'h22}));
                end
                set_ch(2, 32'h22);
                rsp_ready = 1'b1;
            end
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        chk("scan end", 64'({rsp_valid, cmd_ready}), 64'b01);

`ifdef PROBE_SCANNER_FORCE_EN
        do_cmd(2'b01, 8'd1, 32'hCAFE, "put1");
        chk("put1 force_en", 64'(force_en), 64'h02);
`else
        do_cmd(2'b01, 8'd0, 32'hFF, "put0");
        chk("put0 rsp", 64'({r_err, r_data}), 64'({1'b1, 32'h0}));
        chk("put0 force_en", 64'(force_en), 64'h00);
`endif

        // Reset lands in the middle of a scan.
        scan_start("scan2");
        for (int b = 0; b < 4; b++) @(negedge clk);
        chk("scan2 beat4", 64'({rsp_valid, rsp_idx}), 64'({1'b1, 8'd4}));
        rst_n = 1'b0;
        #1;
        chk("midreset rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midreset force_en", 64'(force_en), 64'd0);
        chk("midreset cmd_ready", 64'(cmd_ready), 64'd0);
        rsp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rerelease cmd_ready", 64'(cmd_ready), 64'd1);
        do_cmd(2'b00, 8'd1, 32'h0, "get1");
        chk("get1 rsp", 64'({r_idx, r_err, r_data}), 64'({8'd1, 1'b0, 32'h11}));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
